// File: rtl/wb_ctrl_pkg.sv
// Shared constants, FSM state type and fixed-point helpers for the white-balance
// control scheduler.
package wb_ctrl_pkg;

  localparam logic [1:0] AUTO_GW     = 2'd0;
  localparam logic [1:0] AUTO_R      = 2'd1;
  localparam logic [1:0] MANUAL      = 2'd2;
  localparam logic [1:0] CALIBRATION = 2'd3;

  localparam logic [1:0] MANUAL_RED   = 2'd0;
  localparam logic [1:0] MANUAL_GREEN = 2'd1;
  localparam logic [1:0] MANUAL_BLUE  = 2'd2;

  localparam logic [2:0] ADDR_MODE   = 3'd0;
  localparam logic [2:0] ADDR_R      = 3'd1;
  localparam logic [2:0] ADDR_G      = 3'd2;
  localparam logic [2:0] ADDR_B      = 3'd3;
  localparam logic [2:0] ADDR_CAL    = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  typedef enum logic [1:0] {StIdle, StCommit, StReadWait, StReadRsp} state_t;

  function automatic longint unsigned fixed_one(int unsigned fract);
    return longint'(1) << fract;
  endfunction

  // Value given in units of 1e-4, rounded to nearest at the requested fraction.
  function automatic longint unsigned fixed_scale(int unsigned val_e4, int unsigned fract);
    return ((longint'(val_e4) << fract) + 64'd5000) / 64'd10000;
  endfunction

endpackage

// File: rtl/wb_ctrl_scheduler.sv
// CSR front-end for the white-balance corrector: shadows coefficient/mode writes,
// commits them at frame start, aligns calibration strobes and arbitrates readback.
module wb_ctrl_scheduler
  import wb_ctrl_pkg::*;
#(
  parameter int unsigned COEF_WIDTH   = 20,
  parameter int unsigned FRACT_WIDTH  = 10,
  parameter bit          APPLY_ON_SOF = 1'b1,
  parameter int unsigned READ_LAT     = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  sof_i,
  input  logic                  csr_valid_i,
  input  logic                  csr_we_i,
  input  logic [2:0]            csr_addr_i,
  input  logic [COEF_WIDTH-1:0] csr_wdata_i,
  output logic                  csr_ready_o,
  output logic                  csr_rvalid_o,
  output logic [COEF_WIDTH-1:0] csr_rdata_o,
  output logic [1:0]            mode_o,
  output logic [1:0]            man_sel_o,
  output logic [COEF_WIDTH-1:0] man_coef_o,
  output logic                  man_lock_o,
  output logic                  cal_stb_o,
  input  logic [COEF_WIDTH-1:0] cur_coef_i
);

  localparam logic [COEF_WIDTH-1:0] FixedOne = COEF_WIDTH'(fixed_one(FRACT_WIDTH));
  localparam logic [COEF_WIDTH-1:0] RInit    = COEF_WIDTH'(fixed_scale(24433, FRACT_WIDTH));
  localparam logic [COEF_WIDTH-1:0] BInit    = COEF_WIDTH'(fixed_scale(14082, FRACT_WIDTH));
  localparam int unsigned CntW = (READ_LAT > 1) ? $clog2(READ_LAT + 1) : 1;

  state_t                state_q, state_d;
  logic [1:0]            mode_sh_q, mode_sh_d;
  logic [COEF_WIDTH-1:0] coef_sh_q [3];
  logic [COEF_WIDTH-1:0] coef_sh_d [3];
  logic [3:0]            dirty_q, dirty_d;
  logic                  cal_pend_q, cal_pend_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [1:0]            mode_q, mode_d;
  logic [1:0]            man_sel_q, man_sel_d;
  logic [COEF_WIDTH-1:0] man_coef_q, man_coef_d;
  logic                  man_lock_q, man_lock_d;
  logic                  cal_stb_q, cal_stb_d;
  logic [COEF_WIDTH-1:0] rdata_q, rdata_d;

  logic idle, commit_go, accept, cal_set, picked;

  assign idle      = (state_q == StIdle);
  assign commit_go = idle && (dirty_q != 4'b0) && (sof_i || !APPLY_ON_SOF);
  // Dropping ready while a commit starts keeps a same-cycle request from being lost.
  assign csr_ready_o = rst_n_i && idle && !commit_go;
  assign accept      = csr_valid_i && csr_ready_o;

  assign csr_rvalid_o = (state_q == StReadRsp);
  assign csr_rdata_o  = rdata_q;
  assign mode_o       = mode_q;
  assign man_sel_o    = man_sel_q;
  assign man_coef_o   = man_coef_q;
  assign man_lock_o   = man_lock_q;
  assign cal_stb_o    = cal_stb_q;

  always_comb begin
    state_d    = state_q;
    mode_sh_d  = mode_sh_q;
    coef_sh_d  = coef_sh_q;
    dirty_d    = dirty_q;
    cal_pend_d = cal_pend_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    man_sel_d  = man_sel_q;
    man_coef_d = man_coef_q;
    man_lock_d = 1'b0;
    cal_stb_d  = 1'b0;
    rdata_d    = rdata_q;
    cal_set    = 1'b0;
    picked     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (commit_go) begin
          state_d = StCommit;
        end else if (accept && csr_we_i) begin
          if (csr_addr_i == ADDR_MODE) begin
            mode_sh_d  = csr_wdata_i[1:0];
            dirty_d[0] = 1'b1;
          end
          for (int unsigned i = 0; i < 3; i++) begin
            if (csr_addr_i == 3'(i + 1)) begin
              coef_sh_d[i]   = csr_wdata_i;
              dirty_d[i + 1] = 1'b1;
            end
          end
          cal_set = (csr_addr_i == ADDR_CAL);
        end else if (accept) begin
          if (csr_addr_i inside {ADDR_R, ADDR_G, ADDR_B}) begin
            man_sel_d = csr_addr_i[1:0] - 2'd1;
            cnt_d     = CntW'(READ_LAT);
            state_d   = StReadWait;
          end else begin
            unique case (csr_addr_i)
              ADDR_MODE:   rdata_d = COEF_WIDTH'(mode_q);
              ADDR_STATUS: rdata_d = COEF_WIDTH'({!idle, cal_pend_q, dirty_q});
              default:     rdata_d = '0;
            endcase
            state_d = StReadRsp;
          end
        end
      end
      StCommit: begin
        // One dirty item per cycle, MODE first, then R, G, B.
        if (dirty_q[0]) begin
          mode_d     = mode_sh_q;
          dirty_d[0] = 1'b0;
        end else begin
          for (int unsigned i = 0; i < 3; i++) begin
            if (!picked && dirty_q[i + 1]) begin
              picked         = 1'b1;
              man_sel_d      = 2'(i);
              man_coef_d     = coef_sh_q[i];
              man_lock_d     = 1'b1;
              dirty_d[i + 1] = 1'b0;
            end
          end
        end
        if (dirty_d == 4'b0) state_d = StIdle;
      end
      StReadWait: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q <= CntW'(1)) begin
          rdata_d = cur_coef_i;
          state_d = StReadRsp;
        end
      end
      StReadRsp: state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    if (sof_i && cal_pend_q && (mode_q == CALIBRATION) && (state_q != StCommit)) begin
      cal_stb_d  = 1'b1;
      cal_pend_d = 1'b0;
    end
    if (cal_set) cal_pend_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= StIdle;
      mode_sh_q    <= AUTO_GW;
      coef_sh_q[0] <= RInit;
      coef_sh_q[1] <= FixedOne;
      coef_sh_q[2] <= BInit;
      dirty_q      <= 4'b0;
      cal_pend_q   <= 1'b0;
      cnt_q        <= '0;
      mode_q       <= AUTO_GW;
      man_sel_q    <= MANUAL_RED;
      man_coef_q   <= '0;
      man_lock_q   <= 1'b0;
      cal_stb_q    <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_sh_q  <= mode_sh_d;
      coef_sh_q  <= coef_sh_d;
      dirty_q    <= dirty_d;
      cal_pend_q <= cal_pend_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      man_sel_q  <= man_sel_d;
      man_coef_q <= man_coef_d;
      man_lock_q <= man_lock_d;
      cal_stb_q  <= cal_stb_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_wb_ctrl_scheduler.sv
// Self-checking bench for wb_ctrl_scheduler: vector table for CSR accesses,
// read/lock scoreboards, and hand sequences for commit, calibration and reset cases.
module tb_wb_ctrl_scheduler;

  localparam int unsigned CW = 20;
  localparam int unsigned RL = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sof = 1'b0;
  logic          csr_valid = 1'b0;
  logic          csr_we = 1'b0;
  logic [2:0]    csr_addr = '0;
  logic [CW-1:0] csr_wdata = '0;
  logic          csr_ready, csr_rvalid, man_lock, cal_stb;
  logic [CW-1:0] csr_rdata, man_coef, cur_coef;
  logic [1:0]    mode, man_sel;

  // Corrector model: applied coefficients start at the corrector's own defaults.
  logic [CW-1:0] corr [3] = '{20'h009C6, 20'h00400, 20'h005A2};

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int cal_cnt = 0;
  int lock_log[$];

  typedef struct {logic [CW-1:0] data; int due;} rd_exp_t;
  typedef struct {logic [1:0] sel; logic [CW-1:0] coef;} lock_exp_t;
  typedef struct {bit we; logic [2:0] addr; logic [CW-1:0] wdata; logic [CW-1:0] exp;} vec_t;

  rd_exp_t   rdq[$];
  lock_exp_t lockq[$];

  wb_ctrl_scheduler #(
    .COEF_WIDTH  (CW),
    .FRACT_WIDTH (10),
    .APPLY_ON_SOF(1'b1),
    .READ_LAT    (RL)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .sof_i       (sof),
    .csr_valid_i (csr_valid),
    .csr_we_i    (csr_we),
    .csr_addr_i  (csr_addr),
    .csr_wdata_i (csr_wdata),
    .csr_ready_o (csr_ready),
    .csr_rvalid_o(csr_rvalid),
    .csr_rdata_o (csr_rdata),
    .mode_o      (mode),
    .man_sel_o   (man_sel),
    .man_coef_o  (man_coef),
    .man_lock_o  (man_lock),
    .cal_stb_o   (cal_stb),
    .cur_coef_i  (cur_coef)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (man_lock && man_sel < 2'd3) corr[man_sel] <= man_coef;

  always_comb begin
    cur_coef = '0;
    case (man_sel)
      2'd0:    cur_coef = corr[0];
      2'd1:    cur_coef = corr[1];
      2'd2:    cur_coef = corr[2];
      default: cur_coef = '0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Read-response and lock scoreboards.
  always @(negedge clk) begin
    if (csr_rvalid) begin
      if (rdq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rvalid_unexpected: rdata=0x%0h at cycle %0d, none expected", csr_rdata, cyc);
      end else begin
        rd_exp_t e;
        e = rdq.pop_front();
        check("read_data", 32'(csr_rdata), 32'(e.data));
        check("read_cycle", 32'(cyc), 32'(e.due));
      end
    end
    if (man_lock) begin
      lock_log.push_back(cyc);
      if (lockq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL lock_unexpected: sel=%0d coef=0x%0h, none expected", man_sel, man_coef);
      end else begin
        lock_exp_t l;
        l = lockq.pop_front();
        check("lock_sel", 32'(man_sel), 32'(l.sel));
        check("lock_coef", 32'(man_coef), 32'(l.coef));
      end
    end
    if (cal_stb) cal_cnt++;
  end

  task automatic do_req(input bit we, input logic [2:0] addr, input logic [CW-1:0] wdata,
                        input logic [CW-1:0] exp);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    csr_valid = 1'b1;
    csr_we    = we;
    csr_addr  = addr;
    csr_wdata = wdata;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (csr_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL req_timeout: addr=%0d ready=%0b, required 1", addr, csr_ready);
    end else if (!we) begin
      rd_exp_t e;
      e.data = exp;
      e.due  = cyc + 1 + ((addr >= 3'd1 && addr <= 3'd3) ? RL : 0);
      rdq.push_back(e);
    end
    @(posedge clk);
    #1 csr_valid = 1'b0;
  endtask

  task automatic drain_reads();
    for (int n = 0; n < 20 && rdq.size() != 0; n++) @(negedge clk);
    check("read_drain", 32'(rdq.size()), 32'd0);
  endtask

  task automatic pulse_sof();
    @(negedge clk);
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
  endtask

  task automatic push_lock(input logic [1:0] sel, input logic [CW-1:0] coef);
    lock_exp_t l;
    l.sel  = sel;
    l.coef = coef;
    lockq.push_back(l);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mode"}, 32'(mode), 32'd0);
    check({tag, "_sel"}, 32'(man_sel), 32'd0);
    check({tag, "_coef"}, 32'(man_coef), 32'd0);
    check({tag, "_lock"}, 32'(man_lock), 32'd0);
    check({tag, "_cal"}, 32'(cal_stb), 32'd0);
    check({tag, "_rvalid"}, 32'(csr_rvalid), 32'd0);
    check({tag, "_rdata"}, 32'(csr_rdata), 32'd0);
    check({tag, "_ready"}, 32'(csr_ready), 32'd0);
  endtask

  vec_t tbl[12];

  initial begin
    int mode_cyc, lock_cyc, rv_cnt;

    tbl[0]  = '{1'b0, 3'd5, 20'h0, 20'h00000};  // STATUS
    tbl[1]  = '{1'b0, 3'd0, 20'h0, 20'h00000};  // MODE
    tbl[2]  = '{1'b0, 3'd1, 20'h0, 20'h009C6};  // R live
    tbl[3]  = '{1'b0, 3'd2, 20'h0, 20'h00400};
    tbl[4]  = '{1'b0, 3'd3, 20'h0, 20'h005A2};
    tbl[5]  = '{1'b0, 3'd6, 20'h0, 20'h00000};
    tbl[6]  = '{1'b1, 3'd7, 20'hABCDE, 20'h0};  // ignored
    tbl[7]  = '{1'b0, 3'd7, 20'h0, 20'h00000};
    tbl[8]  = '{1'b0, 3'd4, 20'h0, 20'h00000};  // CAL reads 0
    tbl[9]  = '{1'b1, 3'd1, 20'h00800, 20'h0};
    tbl[10] = '{1'b1, 3'd3, 20'h00C00, 20'h0};
    tbl[11] = '{1'b0, 3'd5, 20'h0, 20'h0000A};  // dirty R,B

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    foreach (tbl[i]) do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp);
    drain_reads();
    do_req(1'b0, 3'd1, '0, 20'h009C6);  // shadow write must not reach the live value
    drain_reads();

    // Commit of R and B at the frame boundary.
    repeat (4) @(negedge clk);
    check("no_lock_before_sof", 32'(lock_log.size()), 32'd0);
    push_lock(2'd0, 20'h00800);
    push_lock(2'd2, 20'h00C00);
    pulse_sof();
    repeat (5) @(negedge clk);
    check("lock_count", 32'(lock_log.size()), 32'd2);
    if (lock_log.size() == 2) check("lock_back_to_back", 32'(lock_log[1] - lock_log[0]), 32'd1);
    check("lock_drain", 32'(lockq.size()), 32'd0);
    do_req(1'b0, 3'd5, '0, 20'h00000);
    do_req(1'b0, 3'd1, '0, 20'h00800);
    do_req(1'b0, 3'd3, '0, 20'h00C00);
    drain_reads();

    // MODE commits one cycle ahead of the G lock.
    do_req(1'b1, 3'd0, 20'h2, '0);
    do_req(1'b1, 3'd2, 20'h00400, '0);
    push_lock(2'd1, 20'h00400);
    mode_cyc = -1;
    lock_cyc = -1;
    pulse_sof();
    for (int k = 0; k < 6; k++) begin
      if (mode == 2'd2 && mode_cyc < 0) mode_cyc = cyc;
      if (man_lock) lock_cyc = cyc;
      @(negedge clk);
    end
    check("mode_committed", 32'(mode), 32'd2);
    check("mode_before_lock", 32'(lock_cyc - mode_cyc), 32'd1);
    do_req(1'b0, 3'd0, '0, 20'h2);
    drain_reads();

    // sof during READ_WAIT defers the pending R commit.
    do_req(1'b1, 3'd1, 20'h00123, '0);
    do_req(1'b0, 3'd2, '0, 20'h00400);
    @(negedge clk);
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
    drain_reads();
    repeat (3) @(negedge clk);
    do_req(1'b0, 3'd5, '0, 20'h00002);
    drain_reads();
    push_lock(2'd0, 20'h00123);
    pulse_sof();
    repeat (4) @(negedge clk);
    check("deferred_lock_drain", 32'(lockq.size()), 32'd0);
    do_req(1'b0, 3'd1, '0, 20'h00123);
    drain_reads();

    // Calibration only fires in CALIBRATION mode, once.
    do_req(1'b1, 3'd0, 20'h0, '0);
    pulse_sof();
    repeat (3) @(negedge clk);
    do_req(1'b1, 3'd4, 20'h1, '0);
    do_req(1'b1, 3'd4, 20'h1, '0);
    pulse_sof();
    repeat (3) @(negedge clk);
    check("cal_blocked_mode0", 32'(cal_cnt), 32'd0);
    do_req(1'b0, 3'd5, '0, 20'h00010);
    drain_reads();
    do_req(1'b1, 3'd0, 20'h3, '0);
    pulse_sof();
    repeat (3) @(negedge clk);
    check("mode_cal", 32'(mode), 32'd3);
    check("cal_not_on_commit_sof", 32'(cal_cnt), 32'd0);
    pulse_sof();
    repeat (3) @(negedge clk);
    pulse_sof();
    repeat (3) @(negedge clk);
    check("cal_single_pulse", 32'(cal_cnt), 32'd1);
    do_req(1'b0, 3'd5, '0, 20'h00000);
    drain_reads();

    // Reset in the middle of a commit.
    do_req(1'b1, 3'd1, 20'h00111, '0);
    do_req(1'b1, 3'd2, 20'h00222, '0);
    do_req(1'b1, 3'd3, 20'h00333, '0);
    push_lock(2'd0, 20'h00111);
    pulse_sof();
    for (int n = 0; n < 10 && !man_lock; n++) @(negedge clk);
    check("mid_commit_lock_seen", 32'(man_lock), 32'd1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_commit");
    lockq.delete();
    rst_n = 1'b1;
    do_req(1'b0, 3'd5, '0, 20'h00000);
    drain_reads();
    pulse_sof();
    repeat (4) @(negedge clk);
    do_req(1'b0, 3'd1, '0, 20'h00111);
    do_req(1'b0, 3'd0, '0, 20'h00000);
    drain_reads();

    // Reset in the middle of a coefficient read: no response may follow.
    @(negedge clk);
    csr_valid = 1'b1;
    csr_we    = 1'b0;
    csr_addr  = 3'd2;
    @(posedge clk);
    #1 csr_valid = 1'b0;
    @(negedge clk);
    check("read_wait_sel", 32'(man_sel), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_read");
    rst_n = 1'b1;
    rv_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (csr_rvalid) rv_cnt++;
    end
    check("aborted_read_no_rvalid", 32'(rv_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
